// File: rtl/pipe_ctrl_v.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_v
//
// Front-end pipeline controller. It owns the fetch PC and the IF/ID pipeline
// register and carries out the hazard unit's decisions:
//   - stall : freeze PC and IF/ID, request a bubble into ID/EX
//   - flush : redirect PC to the branch/jump target resolved in EX and
//             replace the IF/ID contents with a NOP
// It also keeps two saturating counters, one for stalled cycles and one for
// flush events, which are used during performance bring-up.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high (wins over everything)
//   stall          load-use stall request from the hazard unit
//   flush          taken branch/jump resolved in EX
//   branch_target  redirect address, used only while flush=1
//   imem_instr     instruction at the current pc (combinational imem read)
//   pc             current fetch address (registered)
//   ifid_pc        PC of the instruction held in IF/ID
//   ifid_instr     instruction held in IF/ID
//   ifid_valid     IF/ID holds a real instruction
//   idex_bubble    ID/EX must load zeroed control on this edge (combinational)
//   stall_cnt      stalled cycles, saturating at all-ones
//   flush_cnt      flush events, saturating at all-ones
// -----------------------------------------------------------------------------
module pipe_ctrl_v #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Action taken on the coming edge, resolved with priority
    // reset > flush > stall > advance.
    typedef enum logic [1:0] {
        ACT_RESET   = 2'd0,
        ACT_FLUSH   = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_ADVANCE = 2'd3
    } action_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam int               N_CNT    = 2;
    localparam int               CNT_STALL = 0;
    localparam int               CNT_FLUSH = 1;

    action_e     action;

    logic [31:0] pc_reg,         pc_next;
    logic [31:0] ifid_pc_reg,    ifid_pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        ifid_valid_reg, ifid_valid_next;

    logic [31:0]      pc_plus4;
    logic [31:0]      redirect_pc;
    logic [N_CNT-1:0] cnt_inc;

    // -------------------------------------------------------------------------
    // Action decode
    // -------------------------------------------------------------------------
    always_comb begin
        action = ACT_ADVANCE;
        if (rst) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (stall) begin
            action = ACT_STALL;
        end
    end

    // ID/EX has to take a bubble whenever the front end does not hand over a
    // fresh instruction this edge, including while held in reset.
    assign idex_bubble = rst | stall | flush;

    // Natural 32-bit wrap: FFFF_FFFC + 4 rolls over to 0.
    assign pc_plus4 = pc_reg + 32'd4;

    // Fetch addresses are word aligned; low target bits are dropped.
    assign redirect_pc = {branch_target[31:2], 2'b00};

    // -------------------------------------------------------------------------
    // PC and IF/ID next-state
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next         = pc_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;

        unique case (action)
            ACT_RESET: begin
                pc_next         = RESET_PC;
                ifid_pc_next    = 32'd0;
                ifid_instr_next = NOP_INSTR;
                ifid_valid_next = 1'b0;
            end
            ACT_FLUSH: begin
                // The wrong-path instruction in IF/ID is killed; the target is
                // fetched on the following cycle.
                pc_next         = redirect_pc;
                ifid_pc_next    = 32'd0;
                ifid_instr_next = NOP_INSTR;
                ifid_valid_next = 1'b0;
            end
            ACT_STALL: begin
                // Everything holds, whether or not IF/ID is valid.
                pc_next         = pc_reg;
            end
            ACT_ADVANCE: begin
                pc_next         = pc_plus4;
                ifid_pc_next    = pc_reg;
                ifid_instr_next = imem_instr;
                ifid_valid_next = 1'b1;
            end
            default: begin
                pc_next         = pc_reg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC;
            ifid_pc_reg    <= 32'd0;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
        end
    end

    assign pc         = pc_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;
    assign ifid_valid = ifid_valid_reg;

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // A stall that coincides with a flush is not counted as a stalled cycle,
    // since the flush wins and nothing is actually held.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_inc            = '0;
        cnt_inc[CNT_STALL] = (action == ACT_STALL);
        cnt_inc[CNT_FLUSH] = (action == ACT_FLUSH);
    end

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[CNT_STALL].cnt_reg;
    assign flush_cnt = g_cnt[CNT_FLUSH].cnt_reg;

endmodule
